debounce_multi: RTL

Parametrised N-channel push-button debouncer. Each channel synchronises an asynchronous button input, filters bounce with a per-channel stability counter, and produces a clean level plus single-cycle press and release pulses. Sits between board button pins and the user-logic control FSMs (LED brightness, mode select). Replaces per-button single-channel debounce instances.

---
 rtl/debounce_multi.sv | 96 +++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: synchroniser, stability counter, press/release pulses.
// Define LONG_PRESS_EN to add a per-channel long-press pulse after LONG_CNT held cycles.
module debounce_multi #(
    parameter int          NCH         = 4,
    parameter int          CNT_W       = 18,
    parameter int unsigned STABLE_CNT  = 250000,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned LONG_CNT    = 50000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] btn_in,
    output logic [NCH-1:0] btn_state,
    output logic [NCH-1:0] press_pulse,
    output logic [NCH-1:0] release_pulse,
    output logic [NCH-1:0] long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    // Elaboration-time range check on the configuration.
    if (NCH < 1 || SYNC_STAGES < 2 || STABLE_CNT < 1 || LONG_CNT < 1) begin : g_bad_params
        $error("debounce_multi: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q [NCH];
    logic [CNT_W-1:0]       cnt    [NCH];
    logic [NCH-1:0]         s;
    logic [NCH-1:0]         mismatch;
    logic [NCH-1:0]         commit;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign s[i]        = sync_q[i][SYNC_STAGES-1];
        assign mismatch[i] = s[i] ^ btn_state[i];
        assign commit[i]   = mismatch[i] && (cnt[i] == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= '0;
                cnt[i]    <= '0;
            end
            btn_state     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_in[i]};
                // Any return to the committed level drops partial progress.
                if (!mismatch[i] || commit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            btn_state     <= btn_state ^ commit;
            press_pulse   <= commit & s;
            release_pulse <= commit & ~s;
        end
    end

`ifdef LONG_PRESS_EN
    localparam logic [31:0] HOLD_LAST = 32'(LONG_CNT - 1);

    logic [31:0] hcnt [NCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                hcnt[i] <= '0;
            end
            long_press <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (commit[i] && s[i]) begin
                    hcnt[i]       <= '0;
                    long_press[i] <= (HOLD_LAST == 32'd0);
                end else if (!btn_state[i] || commit[i]) begin
                    hcnt[i]       <= '0;
                    long_press[i] <= 1'b0;
                end else if (hcnt[i] != HOLD_LAST) begin
                    hcnt[i]       <= hcnt[i] + 32'd1;
                    long_press[i] <= (hcnt[i] + 32'd1 == HOLD_LAST);
                end else begin
                    // Saturated: one pulse per press.
                    long_press[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign long_press = '0;
`endif

endmodule
